// File: rtl/key_matrix_scan_if.sv
// Keypad-side bus of key_matrix_scan: row drive, column sense and the
// confirmed-key reporting signals consumed by UART/display logic.
interface key_matrix_scan_if;
    logic [3:0] key_row;
    logic [3:0] key_col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_release;
    logic       key_down;

    modport master (
        output key_row,
        output key_code,
        output key_valid,
        output key_release,
        output key_down,
        input  key_col
    );

    modport slave (
        input  key_row,
        input  key_code,
        input  key_valid,
        input  key_release,
        input  key_down,
        output key_col
    );
endinterface

// File: rtl/key_matrix_scan.sv
// 4x4 active-low keypad scanner: 1 ms row rotation, per-frame snapshot and a
// debounce FSM that reports one confirmed press/release per key.
module key_matrix_scan #(
    parameter int CLK_FREQ        = 50,
    parameter int DEBOUNCE_FRAMES = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    key_matrix_scan_if.master bus
);
    localparam int               TICK_COUNT = CLK_FREQ * 1000;
    localparam int               TICK_W     = $clog2(TICK_COUNT);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_COUNT - 1);
    localparam logic [3:0]       DEB_LAST   = 4'(DEBOUNCE_FRAMES);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        DEB_RELEASE = 2'd3
    } state_e;

    function automatic logic [4:0] ones16(input logic [15:0] v);
        logic [4:0] sum;
        sum = 5'd0;
        for (int i = 0; i < 16; i++) begin
            sum = sum + 5'(v[i]);
        end
        return sum;
    endfunction

    function automatic logic [3:0] first_set(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            idx = v[i] ? 4'(i) : idx;
        end
        return idx;
    endfunction

    logic [TICK_W-1:0] tick_cnt_q;
    logic [3:0]        col_meta_q;
    logic [3:0]        col_sync_q;
    logic [3:0]        row_q;
    logic [1:0]        row_idx_q;
    logic [15:0]       snap_q;
    logic              frame_done_q;

    state_e            state_q, state_d;
    logic [3:0]        cand_q, cand_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [3:0]        key_code_q, key_code_d;
    logic              key_valid_q, key_valid_d;
    logic              key_release_q, key_release_d;
    logic              key_down_q, key_down_d;

    logic              tick_s;
    logic              single_s;
    logic [3:0]        single_code_s;
    logic [3:0]        cnt_inc_s;

    assign tick_s = (tick_cnt_q == TICK_LAST);

    // Free-running time base, column synchronizer and row scan; never stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt_q   <= '0;
            col_meta_q   <= 4'hF;
            col_sync_q   <= 4'hF;
            row_q        <= 4'b1110;
            row_idx_q    <= 2'd0;
            snap_q       <= 16'h0000;
            frame_done_q <= 1'b0;
        end else begin
            col_meta_q   <= bus.key_col;
            col_sync_q   <= col_meta_q;
            frame_done_q <= tick_s && (row_idx_q == 2'd3);
            if (tick_s) begin
                tick_cnt_q                          <= '0;
                snap_q[{row_idx_q, 2'b00} +: 4]     <= ~col_sync_q;
                row_q                               <= {row_q[2:0], row_q[3]};
                row_idx_q                           <= row_idx_q + 2'd1;
            end else begin
                tick_cnt_q <= tick_cnt_q + TICK_W'(1);
            end
        end
    end

    // Frame classification: MULTI and NONE both read as "not single".
    always_comb begin
        single_s      = (ones16(snap_q) == 5'd1);
        single_code_s = first_set(snap_q);
        cnt_inc_s     = cnt_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cand_q  <= 4'd0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        if (frame_done_q) begin
            case (state_q)
                IDLE: begin
                    if (single_s) begin
                        state_d = DEB_PRESS;
                        cand_d  = single_code_s;
                        cnt_d   = 4'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                DEB_PRESS: begin
                    if (single_s && (single_code_s == cand_q)) begin
                        cnt_d   = cnt_inc_s;
                        state_d = (cnt_inc_s == DEB_LAST) ? PRESSED : DEB_PRESS;
                    end else if (single_s) begin
                        cand_d  = single_code_s;
                        cnt_d   = 4'd1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                    end
                end
                PRESSED: begin
                    if (single_s && (single_code_s == key_code_q)) begin
                        state_d = PRESSED;
                    end else begin
                        state_d = DEB_RELEASE;
                        cnt_d   = 4'd1;
                    end
                end
                DEB_RELEASE: begin
                    if (single_s && (single_code_s == key_code_q)) begin
                        state_d = PRESSED;
                    end else begin
                        cnt_d   = cnt_inc_s;
                        state_d = (cnt_inc_s == DEB_LAST) ? IDLE : DEB_RELEASE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Pulses are derived from the confirming transitions only.
    always_comb begin
        key_valid_d   = frame_done_q && (state_q == DEB_PRESS) && (state_d == PRESSED);
        key_release_d = frame_done_q && (state_q == DEB_RELEASE) && (state_d == IDLE);
        key_code_d    = key_valid_d ? cand_q : key_code_q;
        key_down_d    = (state_d == PRESSED) || (state_d == DEB_RELEASE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_code_q    <= 4'd0;
            key_valid_q   <= 1'b0;
            key_release_q <= 1'b0;
            key_down_q    <= 1'b0;
        end else begin
            key_code_q    <= key_code_d;
            key_valid_q   <= key_valid_d;
            key_release_q <= key_release_d;
            key_down_q    <= key_down_d;
        end
    end

    assign bus.key_row     = row_q;
    assign bus.key_code    = key_code_q;
    assign bus.key_valid   = key_valid_q;
    assign bus.key_release = key_release_q;
    assign bus.key_down    = key_down_q;
endmodule

// File: tb/tb_key_matrix_scan.sv
// Scoreboard bench for key_matrix_scan: a frame-level keypad model predicts
// press/release events; a monitor matches them against the DUT pulses.
module tb_key_matrix_scan;
    localparam int CLK_FREQ = 1;
    localparam int DEB      = 3;
    localparam int TICK     = CLK_FREQ * 1000;

    typedef struct {
        bit       is_rel;
        logic [3:0] code;
        int       t;
    } ev_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] pressed;
    logic [3:0]  col_s;

    int  checks = 0;
    int  errors = 0;
    int  mcyc;
    int  n_valid = 0;
    int  n_rel = 0;
    int  last_valid_t = 0;
    int  last_rel_t = 0;
    ev_t exp_q[$];

    key_matrix_scan_if bus();

    key_matrix_scan #(.CLK_FREQ(CLK_FREQ), .DEBOUNCE_FRAMES(DEB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Passive keypad: a column reads low when a pressed key sits on a driven row.
    always_comb begin
        col_s = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!bus.key_row[r] && pressed[r*4+c]) col_s[c] = 1'b0;
            end
        end
    end
    assign bus.key_col = col_s;

    // Reference model: one snapshot per row tick, rules applied per whole frame
    // over the history of frame classes since the last confirmed event.
    initial begin : model
        logic [15:0] mframe;
        int hist[$];
        bit held;
        int hcode;
        int r, cls, last;
        bit all_same, all_not_held;
        ev_t e;
        mcyc = -1;
        mframe = 16'h0000;
        held = 1'b0;
        hcode = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                mcyc = 0;
                mframe = 16'h0000;
                held = 1'b0;
                hist.delete();
            end else begin
                if ((mcyc % TICK) == TICK - 1) begin
                    r = (mcyc / TICK) % 4;
                    for (int c = 0; c < 4; c++) mframe[r*4+c] = pressed[r*4+c];
                    if (r == 3) begin
                        cls = -1;
                        if ($countones(mframe) == 1) begin
                            for (int k = 0; k < 16; k++) if (mframe[k]) cls = k;
                        end
                        hist.push_back(cls);
                        if (hist.size() >= DEB) begin
                            last = hist[hist.size()-1];
                            all_same = (last >= 0);
                            all_not_held = 1'b1;
                            for (int i = 0; i < DEB; i++) begin
                                if (hist[hist.size()-1-i] != last) all_same = 1'b0;
                                if (hist[hist.size()-1-i] == hcode) all_not_held = 1'b0;
                            end
                            if (!held && all_same) begin
                                e.is_rel = 1'b0; e.code = 4'(last); e.t = mcyc + 2;
                                exp_q.push_back(e);
                                held = 1'b1; hcode = last; hist.delete();
                            end else if (held && all_not_held) begin
                                e.is_rel = 1'b1; e.code = 4'(hcode); e.t = mcyc + 2;
                                exp_q.push_back(e);
                                held = 1'b0; hist.delete();
                            end
                        end
                    end
                end
                mcyc = mcyc + 1;
            end
        end
    end

    // Monitor: row pattern every cycle, pulses matched against the expected queue.
    initial begin : monitor
        ev_t e;
        logic [3:0] exp_row;
        int d;
        forever begin
            @(negedge clk);
            if (mcyc >= 0) begin
                exp_row = ~(4'b0001 << ((mcyc / TICK) % 4));
                checks++;
                if (bus.key_row !== exp_row) begin
                    errors++;
                    if (errors < 40) $display("FAIL key_row @%0d: got %b expected %b", mcyc, bus.key_row, exp_row);
                end
                if (bus.key_valid === 1'b1 || bus.key_release === 1'b1) begin
                    if (bus.key_valid === 1'b1) begin n_valid++; last_valid_t = mcyc; end
                    if (bus.key_release === 1'b1) begin n_rel++; last_rel_t = mcyc; end
                    checks++;
                    if (bus.key_valid === 1'b1 && bus.key_release === 1'b1) begin
                        errors++;
                        $display("FAIL both_pulses @%0d: got valid=1 release=1 expected at most one", mcyc);
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_pulse @%0d: got valid=%b release=%b code=%h expected none",
                                 mcyc, bus.key_valid, bus.key_release, bus.key_code);
                    end else begin
                        e = exp_q.pop_front();
                        d = mcyc - e.t;
                        if ((bus.key_release !== e.is_rel) || (bus.key_code !== e.code) ||
                            (bus.key_down !== !e.is_rel) || (d < -1) || (d > 1)) begin
                            errors++;
                            $display("FAIL event @%0d: got rel=%b code=%h down=%b expected rel=%b code=%h down=%b at %0d",
                                     mcyc, bus.key_release, bus.key_code, bus.key_down,
                                     e.is_rel, e.code, !e.is_rel, e.t);
                        end
                    end
                end
                if (exp_q.size() > 0 && mcyc > exp_q[0].t + 1) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_pulse @%0d: got no pulse expected rel=%b code=%h at %0d",
                             mcyc, exp_q[0].is_rel, exp_q[0].code, exp_q[0].t);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic check_val(input string name, input logic [3:0] got, input logic [3:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, expv);
        end
    endtask

    task automatic wait_safe();
        while ((mcyc % TICK) < 10 || (mcyc % TICK) > TICK - 15) @(negedge clk);
    endtask

    task automatic wait_pulse(input bit rel, input int budget, input string name);
        int start;
        int k;
        start = rel ? n_rel : n_valid;
        k = 0;
        while (((rel ? n_rel : n_valid) == start) && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if ((rel ? n_rel : n_valid) == start) begin
            errors++;
            $display("FAIL %s: got no pulse within %0d clk expected one", name, budget);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_row"}, bus.key_row, 4'b1110);
        check_val({tag, "_down"}, {3'b000, bus.key_down}, 4'd0);
        check_val({tag, "_valid"}, {3'b000, bus.key_valid}, 4'd0);
        check_val({tag, "_release"}, {3'b000, bus.key_release}, 4'd0);
    endtask

    initial begin : stimulus
        int base;
        pressed = 16'h0000;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_reset_outputs("reset");
        check_val("reset_code", bus.key_code, 4'h0);
        repeat ($urandom_range(100, 1500)) @(negedge clk);

        // Bounce on key 0x5: too short to yield three consecutive pressed frames.
        for (int i = 0; i < 10; i++) begin
            wait_safe();
            pressed[5] = ~pressed[5];
            repeat ($urandom_range(200, 500)) @(negedge clk);
        end
        check_val("bounce_no_valid", 4'(n_valid), 4'd0);
        wait_safe();
        pressed = 16'h0020;
        wait_pulse(1'b0, 16500, "press_0x5");

        // Reset while PRESSED with the key still held.
        repeat ($urandom_range(100, 500)) @(negedge clk);
        wait_safe();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_outputs("midreset");
        wait_pulse(1'b0, 16500, "repress_0x5");

        // Two keys together (0x3 + 0xC): release of 0x5, but no press.
        wait_safe();
        pressed = 16'h1008;
        wait_pulse(1'b1, 16500, "release_0x5_multi");
        base = n_valid;
        repeat (2000) @(negedge clk);
        check_val("multi_no_valid", 4'(n_valid - base), 4'd0);
        wait_safe();
        pressed = 16'h0008;
        wait_pulse(1'b0, 16500, "press_0x3");

        // Key change while held: 0x3 -> 0x0 directly.
        wait_safe();
        pressed = 16'h0001;
        wait_pulse(1'b1, 16500, "release_0x3_change");
        check_val("release_code_kept", bus.key_code, 4'h3);
        wait_pulse(1'b0, 16500, "press_0x0_change");
        checks++;
        if (last_valid_t - last_rel_t < DEB * 4 * TICK) begin
            errors++;
            $display("FAIL change_gap: got %0d clk expected at least %0d", last_valid_t - last_rel_t, DEB * 4 * TICK);
        end

        repeat (50) @(negedge clk);
        check_val("final_code", bus.key_code, 4'h0);
        check_val("final_down", {3'b000, bus.key_down}, 4'd1);
        check_val("queue_drained", 4'(exp_q.size()), 4'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
